// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: multi-cycle control FSM for the RV32I core.
// It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
// It drives the immediate select and the operand, writeback and PC selects.
// It handshakes with the instruction and data memories, counts retired
// instructions, and halts on illegal or SYSTEM opcodes and on memory timeout.
// Ports:
//   clk, rst                      clock, async active-high reset
//   imem_req/imem_ack/ir_in/ir_we instruction fetch handshake and IR load strobe
//   imm_type, alu_a_pc, alu_b_imm immediate type and ALU operand selects
//   branch_taken                  ALU compare result, sampled in EXEC
//   dmem_req/dmem_we/dmem_ack     data memory handshake
//   rf_we, wb_sel                 register file write strobe and source select
//   pc_we, pc_sel                 PC update strobe and source select
//   instret                       retired instruction counter (wraps)
//   halted, illegal, bus_err      sticky status flags
module rv32i_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] ir_in,
  output logic        ir_we,
  output logic [2:0]  imm_type,
  output logic        alu_a_pc,
  output logic        alu_b_imm,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] instret,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 32'd1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [2:0]        imm_type_q, imm_type_d;
  logic              alu_a_pc_q, alu_a_pc_d;
  logic              alu_b_imm_q, alu_b_imm_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic              rf_we_q, rf_we_d;
  logic              pc_we_q, pc_we_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic [31:0]       instret_q, instret_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              enter_wb;

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  logic unused_ir;
  assign unused_ir = ^ir_in[31:7];

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC: return 3'b011;
      OP_JAL:           return 3'b100;
      OP_STORE:         return 3'b010;
      OP_BRANCH:        return 3'b001;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] wb_of(input logic [6:0] op);
    case (op)
      OP_LOAD:         return 2'b01;
      OP_JAL, OP_JALR: return 2'b10;
      default:         return 2'b00;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_MISC: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // IR load strobe follows the fetch ack directly; an ack with no request is ignored.
  assign ir_we = (state_q == S_FETCH) && imem_req_q && imem_ack;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = wait_q;
    imem_req_d  = imem_req_q;
    dmem_req_d  = dmem_req_q;
    dmem_we_d   = dmem_we_q;
    imm_type_d  = imm_type_q;
    alu_a_pc_d  = alu_a_pc_q;
    alu_b_imm_d = alu_b_imm_q;
    wb_sel_d    = wb_sel_q;
    rf_we_d     = 1'b0;
    pc_we_d     = 1'b0;
    pc_sel_d    = 2'b00;
    instret_d   = instret_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    enter_wb    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!imem_req_q) begin
          // First cycle out of reset: raise the request.
          imem_req_d = 1'b1;
          wait_d     = '0;
        end else if (imem_ack) begin
          imem_req_d  = 1'b0;
          op_d        = ir_in[6:0];
          imm_type_d  = imm_of(ir_in[6:0]);
          alu_a_pc_d  = (ir_in[6:0] == OP_AUIPC) || (ir_in[6:0] == OP_JAL) ||
                        (ir_in[6:0] == OP_BRANCH);
          alu_b_imm_d = !((ir_in[6:0] == OP_OP) || (ir_in[6:0] == OP_BRANCH));
          wb_sel_d    = wb_of(ir_in[6:0]);
          state_d     = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          imem_req_d = 1'b0;
          bus_err_d  = 1'b1;
          halted_d   = 1'b1;
          state_d    = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (op_q == OP_SYSTEM) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (!is_legal(op_q)) begin
          halted_d  = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
          dmem_req_d = 1'b1;
          dmem_we_d  = (op_q == OP_STORE);
          wait_d     = '0;
          state_d    = S_MEM;
        end else begin
          enter_wb = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          enter_wb   = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          bus_err_d  = 1'b1;
          halted_d   = 1'b1;
          state_d    = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        imem_req_d = 1'b1;
        wait_d     = '0;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Retire: strobes and selects are registered so they appear in the WB cycle.
    // branch_taken is only meaningful here when arriving from EXEC.
    if (enter_wb) begin
      state_d   = S_WB;
      pc_we_d   = 1'b1;
      rf_we_d   = !((op_q == OP_BRANCH) || (op_q == OP_STORE) || (op_q == OP_MISC));
      instret_d = instret_q + 32'd1;
      if (op_q == OP_JALR) begin
        pc_sel_d = 2'b10;
      end else if ((op_q == OP_JAL) || ((op_q == OP_BRANCH) && branch_taken)) begin
        pc_sel_d = 2'b01;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      wait_q      <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      imm_type_q  <= 3'b000;
      alu_a_pc_q  <= 1'b0;
      alu_b_imm_q <= 1'b0;
      wb_sel_q    <= 2'b00;
      rf_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 2'b00;
      instret_q   <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      imm_type_q  <= imm_type_d;
      alu_a_pc_q  <= alu_a_pc_d;
      alu_b_imm_q <= alu_b_imm_d;
      wb_sel_q    <= wb_sel_d;
      rf_we_q     <= rf_we_d;
      pc_we_q     <= pc_we_d;
      pc_sel_q    <= pc_sel_d;
      instret_q   <= instret_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign imm_type  = imm_type_q;
  assign alu_a_pc  = alu_a_pc_q;
  assign alu_b_imm = alu_b_imm_q;
  assign wb_sel    = wb_sel_q;
  assign rf_we     = rf_we_q;
  assign pc_we     = pc_we_q;
  assign pc_sel    = pc_sel_q;
  assign instret   = instret_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed testbench for rv32i_multicycle_ctrl (MAX_WAIT = 4).
module tb_rv32i_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, ir_we;
  logic [31:0] ir_in;
  logic [2:0]  imm_type;
  logic        alu_a_pc, alu_b_imm, branch_taken;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we, pc_we;
  logic [1:0]  wb_sel, pc_sel;
  logic [31:0] instret;
  logic        halted, illegal, bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rv32i_multicycle_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_in(ir_in), .ir_we(ir_we),
    .imm_type(imm_type), .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .instret(instret), .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] ctl_now();
    return 32'({imm_type, alu_a_pc, alu_b_imm, wb_sel});
  endfunction

  // Called in the cycle before fetch cycle 0; returns inside the WB cycle.
  // ctl = {imm_type, alu_a_pc, alu_b_imm, wb_sel}; dwait < 0 means no MEM phase.
  task automatic run_instr(input string name, input logic [31:0] ir, input logic taken,
                           input int dwait, input logic [6:0] ctl, input logic dwe,
                           input logic rfwe, input logic [1:0] psel,
                           input logic [31:0] icnt, input int rcyc);
    cyc = -1;
    nc(); imem_ack = 1'b1; ir_in = ir; #1;
    chk({name, ".fetch_req"}, 32'(imem_req), 32'd1);
    chk({name, ".ir_we"}, 32'(ir_we), 32'd1);
    chk({name, ".prev_pulses_clear"}, 32'({rf_we, pc_we, dmem_req}), 32'd0);
    nc(); imem_ack = 1'b0; #1;
    chk({name, ".dec_ctl"}, ctl_now(), 32'(ctl));
    chk({name, ".dec_req_ir_we"}, 32'({imem_req, ir_we}), 32'd0);
    nc(); branch_taken = taken; #1;
    chk({name, ".exe_ctl"}, ctl_now(), 32'(ctl));
    if (dwait >= 0) begin
      for (int k = 0; k <= dwait; k++) begin
        nc(); dmem_ack = (k == dwait); #1;
        chk({name, ".mem_req_we"}, 32'({dmem_req, dmem_we, imem_req}), 32'({1'b1, dwe, 1'b0}));
      end
    end
    nc(); dmem_ack = 1'b0; branch_taken = 1'b0; #1;
    chk({name, ".wb_rf_pc_we"}, 32'({rf_we, pc_we, dmem_req}), 32'({rfwe, 1'b1, 1'b0}));
    chk({name, ".wb_pc_sel"}, 32'(pc_sel), 32'(psel));
    chk({name, ".wb_instret"}, instret, icnt);
    chk({name, ".wb_ctl"}, ctl_now(), 32'(ctl));
    chk({name, ".wb_cycle"}, 32'(cyc), 32'(rcyc));
  endtask

  // Pulse reset; returns in the cycle right after release.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_halt(input string name, input logic [31:0] ir, input logic [2:0] flags);
    nc(); imem_ack = 1'b1; ir_in = ir; #1;
    chk({name, ".ir_we"}, 32'(ir_we), 32'd1);
    nc(); imem_ack = 1'b0;
    nc(); #1;
    chk({name, ".flags"}, 32'({halted, illegal, bus_err}), 32'(flags));
    for (int k = 0; k < 3; k++) begin
      nc(); imem_ack = 1'b1; #1;
      chk({name, ".halt_quiet"}, 32'({imem_req, ir_we, dmem_req, rf_we, pc_we}), 32'd0);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    imem_ack = 1'b0; ir_in = '0; branch_taken = 1'b0; dmem_ack = 1'b0;

    // Reset state.
    @(negedge clk); #1;
    chk("rst.reqs", 32'({imem_req, dmem_req, dmem_we, ir_we}), 32'd0);
    chk("rst.strobes", 32'({rf_we, pc_we, pc_sel, wb_sel}), 32'd0);
    chk("rst.imm_type", 32'(imm_type), 32'd0);
    chk("rst.instret", instret, 32'd0);
    chk("rst.flags", 32'({halted, illegal, bus_err}), 32'd0);

    // First cycle after release: request still low, stray ack ignored.
    @(negedge clk); rst = 1'b0; imem_ack = 1'b1; #1;
    chk("post_rst.req_low", 32'(imem_req), 32'd0);
    chk("post_rst.ack_ignored", 32'(ir_we), 32'd0);

    run_instr("addi",  32'h7ff00093, 1'b1, -1, 7'b000_0_1_00, 1'b0, 1'b1, 2'b00, 32'd1, 3);
    run_instr("beq_t", 32'h00000463, 1'b1, -1, 7'b001_1_0_00, 1'b0, 1'b0, 2'b01, 32'd2, 3);
    run_instr("beq_n", 32'h00000463, 1'b0, -1, 7'b001_1_0_00, 1'b0, 1'b0, 2'b00, 32'd3, 3);
    run_instr("sw",    32'h00112223, 1'b0,  3, 7'b010_0_1_00, 1'b1, 1'b0, 2'b00, 32'd4, 7);
    run_instr("jal",   32'h008000ef, 1'b0, -1, 7'b100_1_1_10, 1'b0, 1'b1, 2'b01, 32'd5, 3);
    run_instr("jalr",  32'h00008067, 1'b0, -1, 7'b000_0_1_10, 1'b0, 1'b1, 2'b10, 32'd6, 3);
    run_instr("lw",    32'h0000a103, 1'b0,  0, 7'b000_0_1_01, 1'b0, 1'b1, 2'b00, 32'd7, 4);

    // Reset during a MEM wait: clears without a clock edge.
    nc(); imem_ack = 1'b1; ir_in = 32'h00112223;
    nc(); imem_ack = 1'b0;
    nc();
    nc(); #1;
    chk("rst_mem.req_before", 32'(dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mem.req_dropped", 32'({dmem_req, dmem_we, imem_req}), 32'd0);
    chk("rst_mem.instret", instret, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_instr("addi2", 32'h7ff00093, 1'b0, -1, 7'b000_0_1_00, 1'b0, 1'b1, 2'b00, 32'd1, 3);

    // Fetch timeout: MAX_WAIT request cycles with no ack.
    for (int k = 0; k < 4; k++) begin
      nc(); #1;
      chk("tmo.req_held", 32'({imem_req, bus_err}), 32'b10);
    end
    nc(); #1;
    chk("tmo.flags", 32'({halted, bus_err, illegal}), 32'b110);
    chk("tmo.req_dropped", 32'(imem_req), 32'd0);
    chk("tmo.instret", instret, 32'd1);

    do_reset();
    run_halt("illegal", 32'hffffffff, 3'b110);
    do_reset();
    run_halt("ecall", 32'h00000073, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
# rv32i_multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath's `imm_type` select into the immediate extractor. It also drives the PC, register file and memory enables, and handshakes with the instruction and data memories. It counts retired instructions and halts on illegal opcodes, SYSTEM instructions or memory timeouts.

## Interface
- `MAX_WAIT`, 15: maximum cycles a memory request is held without ack before bus error (1..255)
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `imem_req` out 1: instruction fetch request, held until ack
- `imem_ack` in 1: fetch complete; `ir_in` valid this cycle
- `ir_in` in 32: fetched instruction word
- `ir_we` out 1: IR load strobe (= `imem_ack` in FETCH, combinational)
- `imm_type` out 3: 000 I, 001 B, 010 S, 011 U, 100 J; 101–111 never driven
- `alu_a_pc` out 1: ALU operand A = PC (AUIPC, JAL, BRANCH target)
- `alu_b_imm` out 1: ALU operand B = immediate (all except OP, BRANCH compare)
- `branch_taken` in 1: compare result from ALU, sampled in EXEC
- `dmem_req` out 1: data request, held until ack
- `dmem_we` out 1: store when 1, load when 0; valid with `dmem_req`
- `dmem_ack` in 1: data access complete
- `rf_we` out 1: register file write strobe
- `wb_sel` out 2: 00 ALU, 01 load data, 10 PC+4
- `pc_we` out 1: PC update strobe
- `pc_sel` out 2: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
- `instret` out 32: retired instruction count, wraps
- `halted` out 1, `illegal` out 1, `bus_err` out 1: sticky status

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. After reset: FETCH.
- FETCH: `imem_req`=1. On `imem_ack`: `ir_we`=1, opcode `ir_in[6:0]` latched internally, go to DECODE.
- DECODE: 1 cycle. Opcode classes: LUI/AUIPC→U; JAL→J; JALR, LOAD, OP-IMM→I; STORE→S; BRANCH→B; OP, MISC-MEM→I (immediate unused). SYSTEM → HALT (`halted`=1). Any other opcode, or `ir[1:0]`≠11 → HALT with `illegal`=1.
- `imm_type`, `alu_a_pc`, `alu_b_imm` and `wb_sel` are registered from the latched opcode at DECODE entry. They are stable from DECODE through WB.
- EXEC: 1 cycle. `branch_taken` is registered. LOAD/STORE → MEM, else → WB.
- MEM: `dmem_req`=1, `dmem_we`=(STORE). On `dmem_ack` → WB.
- WB: `pc_we`=1. `rf_we`=1 except BRANCH, STORE, MISC-MEM. `pc_sel`=01 for JAL or (BRANCH and registered taken); 10 for JALR; else 00. `instret` +1. Then → FETCH.
- Timeout: a wait counter clears on entering FETCH or MEM and counts cycles with req high and no ack. Ack is accepted in any of the first `MAX_WAIT` request cycles. With no ack by then → HALT, `bus_err`=1, req deasserts.
- HALT: absorbing; all strobes and reqs 0; exited only by `rst`.

## Timing
- Reset (async): state FETCH, all outputs 0, `imm_type`=000, `instret`=0, status flags 0, wait counter 0. `imem_req` rises in the first cycle after `rst` falls.
- Reset mid-operation: state and outputs clear immediately, with no clock edge needed. An outstanding request is dropped; no retire is counted.
- Zero-wait latency: ALU/branch/jump = 4 cycles (FETCH, DECODE, EXEC, WB); load/store = 5 cycles. Each ack wait cycle adds 1.
- `ir_we`, `rf_we` and `pc_we` are single-cycle pulses, exactly one per retired instruction (`rf_we` where applicable).
- `imem_req` and `dmem_req` are never high simultaneously. An ack arriving while its req is low is ignored.
- `instret` wraps from FFFF_FFFF to 0.

## Test plan
- ADDI `0x7ff00093`, ack in first cycle → `ir_we` at cycle 0, `imm_type`=000 in DECODE; WB at cycle 3 with `rf_we`=1, `pc_sel`=00, `instret`=1.
- BEQ `0x00000463` with `branch_taken`=1, then again with 0 → `imm_type`=001, `rf_we`=0, `pc_sel`=01 then 00.
- SW `0x00112223`, `dmem_ack` delayed 3 cycles → `imm_type`=010, `dmem_we`=1, req held 4 cycles, retire at cycle 7.
- JAL `0x008000ef` then JALR `0x00008067` → `imm_type` 100/000, `wb_sel`=10, `pc_sel` 01/10.
- Fetch `0xffffffff` → HALT, `illegal`=1, no further `imem_req`. With `MAX_WAIT`=4 and no ack → `bus_err`=1 after 4 request cycles.
- Assert `rst` during MEM wait → `dmem_req` drops without a clock edge, `instret`=0, FETCH resumes after release.
